// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_NOTB = 2'b11;

endpackage

// File: rtl/alu_addsub.sv
// Combined adder/subtractor. Subtraction is performed as a + ~b + 1.
// With ALU_FLAGS_EN defined, a signed-overflow output is also provided.
module alu_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ALU_FLAGS_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] b_eff;

    // Invert B and inject a carry-in for subtraction; carry-out is dropped.
    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + WIDTH'(sub);
    end

`ifdef ALU_FLAGS_EN
    // Overflow: effective operands share a sign but the result sign differs.
    // For sub this is "a and b differ in sign, result differs from a".
    always_comb begin
        ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
`endif

endmodule

// File: rtl/alu.sv
// Registered 4-operation ALU (add, sub, and, not-B) with a zero flag.
// Optional feature macro ALU_FLAGS_EN adds registered N and V flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       ALUop,
`ifdef ALU_FLAGS_EN
    output logic             N,
    output logic             V,
`endif
    output logic [WIDTH-1:0] out,
    output logic             Z
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             is_sub;

`ifdef ALU_FLAGS_EN
    logic ovf;
    logic v_d;
`endif

    assign is_sub = (ALUop == OP_SUB);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a   (Ain),
        .b   (Bin),
        .sub (is_sub),
`ifdef ALU_FLAGS_EN
        .ovf (ovf),
`endif
        .sum (sum)
    );

    // Select the operation result from the current inputs.
    always_comb begin
        result = sum;
        unique case (ALUop)
            OP_ADD,
            OP_SUB:  result = sum;
            OP_AND:  result = Ain & Bin;
            OP_NOTB: result = ~Bin;
            default: result = sum;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Overflow is only meaningful for the arithmetic operations.
    always_comb begin
        v_d = (ALUop == OP_ADD || ALUop == OP_SUB) ? ovf : 1'b0;
    end
`endif

    // Result and flags load together so Z/N/V never lag out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            Z   <= 1'b1;
`ifdef ALU_FLAGS_EN
            N   <= 1'b0;
            V   <= 1'b0;
`endif
        end else begin
            out <= result;
            Z   <= (result == '0);
`ifdef ALU_FLAGS_EN
            N   <= result[WIDTH-1];
            V   <= v_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/latency
// sequences and randomized operations against an arithmetic model.
module tb_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [1:0]   ALUop;
    logic [W-1:0] out;
    logic         Z;
`ifdef ALU_FLAGS_EN
    logic         N;
    logic         V;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Ain   (Ain),
        .Bin   (Bin),
        .ALUop (ALUop),
`ifdef ALU_FLAGS_EN
        .N     (N),
        .V     (V),
`endif
        .out   (out),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] exp_out;
        logic         exp_z;
        logic         exp_n;
        logic         exp_v;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] op, output logic [W-1:0] r,
                                  output logic v);
        int ua, ub, sa, sb, sres;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - 65536 : ua;
        sb = b[W-1] ? ub - 65536 : ub;
        v  = 1'b0;
        case (op)
            2'd0: begin
                r    = W'((ua + ub) % 65536);
                sres = sa + sb;
                v    = (sres > 32767) || (sres < -32768);
            end
            2'd1: begin
                r    = W'((ua - ub + 65536) % 65536);
                sres = sa - sb;
                v    = (sres > 32767) || (sres < -32768);
            end
            2'd2:    r = a & b;
            default: r = ~b;
        endcase
    endfunction

    task automatic check_outputs(input string name, input logic [W-1:0] eo, input logic ez,
                                 input logic en, input logic ev);
        check({name, ".out"}, 32'(out), 32'(eo));
        check({name, ".Z"}, 32'(Z), 32'(ez));
`ifdef ALU_FLAGS_EN
        check({name, ".N"}, 32'(N), 32'(en));
        check({name, ".V"}, 32'(V), 32'(ev));
`else
        if (en === 1'bx || ev === 1'bx) $display("note: undefined flag expectation");
`endif
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        Ain   = a;
        Bin   = b;
        ALUop = op;
    endtask

    initial begin
        logic [W-1:0] r;
        logic         v;

        vecs[0] = '{16'h5C45, 16'h1FC5, 2'b00, 16'h7C0A, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h5C45, 16'h1FC5, 2'b01, 16'h3C80, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h5C45, 16'h1FC5, 2'b10, 16'h1C45, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h5C45, 16'h1FC5, 2'b11, 16'hE03A, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'hABCD, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b1;
        drive(16'h5C45, 16'h1FC5, 2'b00);
        #1 rst_n = 1'b0;
        #2;
        check_outputs("reset", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Held in reset across an edge: still cleared.
        @(posedge clk); #1;
        check_outputs("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_z,
                          vecs[i].exp_n, vecs[i].exp_v);
        end

        // Async reset while holding 0x7C0A, then release mid-cycle.
        drive(16'h5C45, 16'h1FC5, 2'b00);
        @(posedge clk); #1;
        check_outputs("pre_rst", 16'h7C0A, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(16'h5C45, 16'h1FC5, 2'b01);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check_outputs("rst_release", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("first_after_rst", 16'h3C80, 1'b0, 1'b0, 1'b0);

        // Mid-cycle input change must not reach out before the next edge.
        #2 drive(16'h1234, 16'h1234, 2'b01);
        #1;
        check_outputs("hold_mid", 16'h3C80, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("after_edge", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Back-to-back randomized operations.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            logic [1:0]   op;
            a  = W'($urandom);
            b  = W'($urandom);
            op = 2'($urandom_range(0, 3));
            if (i % 16 == 0) b = a;
            drive(a, b, op);
            model(a, b, op, r, v);
            @(posedge clk); #1;
            check_outputs($sformatf("rand%0d", i), r, (r == '0), r[W-1], v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits; all arithmetic rules below use WIDTH.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Ain  input  WIDTH  operand A.
REQ-005 Port: Bin  input  WIDTH  operand B.
REQ-006 Port: ALUop  input  2  operation select.
REQ-007 Port: out  output  WIDTH  registered result.
REQ-008 Port: Z  output  1  registered zero flag; 1 when out is all zeros.
REQ-009 Port (only with ALU_FLAGS_EN): N  output  1  registered negative flag.
REQ-010 Port (only with ALU_FLAGS_EN): V  output  1  registered signed-overflow flag.

Function
REQ-011 ALUop 2'b00 SHALL compute Ain + Bin, modulo 2^WIDTH; carry-out is discarded.
REQ-012 ALUop 2'b01 SHALL compute Ain - Bin, modulo 2^WIDTH; borrow wraps, e.g. 0x0000 - 0x0001 = 0xFFFF.
REQ-013 ALUop 2'b10 SHALL compute bitwise Ain AND Bin.
REQ-014 ALUop 2'b11 SHALL compute bitwise NOT Bin; Ain is ignored.
REQ-015 Result SHALL be computed combinationally from the current inputs and loaded into out on every rising clk edge; latency is exactly 1 cycle.
REQ-016 Z SHALL be registered on the same edge as out and SHALL equal 1 exactly when the new out value is zero; it never lags out.
REQ-017 There SHALL be no enable or handshake; a new operation is accepted every cycle (throughput 1/cycle).
REQ-018 Input changes between edges SHALL have no effect on out or Z until the next rising edge.

Reset
REQ-019 While rst_n = 0, out SHALL be all zeros and Z SHALL be 1, immediately and without waiting for clk.
REQ-020 With ALU_FLAGS_EN, N and V SHALL be 0 during reset.
REQ-021 Reset deassertion mid-operation SHALL discard any in-flight result; the first valid result appears at the first rising edge after rst_n returns to 1.

Configuration
REQ-022 Macro ALU_FLAGS_EN SHALL control the status flags.
REQ-023 With ALU_FLAGS_EN defined: N = out[WIDTH-1]; V = signed overflow for add (operands same sign, result sign differs) and sub (operands differ in sign, result sign differs from Ain); V = 0 for AND and NOT; both registered with out.
REQ-024 Without ALU_FLAGS_EN, the N and V ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Shared package alu_pkg SHALL hold the ALUop encodings as named constants (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_NOTB=11) and the default width constant.
REQ-026 One sub-module, alu_addsub, SHALL implement the combined adder/subtractor (B inverted plus carry-in for sub) and SHALL produce the sum and overflow outputs.
REQ-027 Operation mux, zero detect and output registers SHALL reside in alu.

Verification
REQ-028 Add: Ain=0x5C45, Bin=0x1FC5, ALUop=00 -> after 1 edge out=0x7C0A, Z=0.
REQ-029 Sub: Ain=0x5C45, Bin=0x1FC5, ALUop=01 -> out=0x3C80, Z=0; Ain=Bin=0x1234 -> out=0x0000, Z=1.
REQ-030 AND: Ain=0x5C45, Bin=0x1FC5, ALUop=10 -> out=0x1C45; NOT: same operands, ALUop=11 -> out=0xE03A.
REQ-031 Wrap: Ain=0xFFFF, Bin=0x0001, ALUop=00 -> out=0x0000, Z=1 (with ALU_FLAGS_EN: N=0, V=0); Ain=0x7FFF, Bin=0x0001 add -> out=0x8000, N=1, V=1.
REQ-032 Async reset: drive rst_n=0 between edges while out=0x7C0A -> out=0x0000 and Z=1 immediately; the first edge after release loads the current operation result.
REQ-033 Latency: change inputs mid-cycle -> out holds its old value until the next rising edge, then shows the new result.
